// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: two-flop sync per channel, then a level is accepted only
// after STABLE_CYCLES consecutive agreeing clocks. Build option: BUTTON_DEBOUNCE_INVERT_EN.
module button_debounce #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] btn_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            btn_raw_c;
  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [WIDTH-1:0]            stable_nxt;
  logic [WIDTH-1:0]            busy_nxt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;

  // Active-low buttons with pull-ups are flipped so that "pressed" is always 1 downstream.
`ifdef BUTTON_DEBOUNCE_INVERT_EN
  assign btn_raw_c = ~btn_in;
`else
  assign btn_raw_c = btn_in;
`endif

  // Per-channel candidate counter; any cycle agreeing with the current level aborts the candidate.
  always_comb begin
    stable_nxt = btn_out;
    busy_nxt   = '0;
    cnt_nxt    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2[i] != btn_out[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
      busy_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  // busy is registered from the next count so it tracks the count register cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      btn_out  <= '0;
      btn_busy <= '0;
      cnt      <= '0;
    end else begin
      sync1    <= btn_raw_c;
      sync2    <= sync1;
      btn_out  <= stable_nxt;
      btn_busy <= busy_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule
